exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit_pkg.sv | 30 +++
 rtl/exec_unit_alu_core.sv | 38 +++
 rtl/exec_unit.sv | 90 +++++++++
 tb/tb_exec_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared encodings for the execute stage: ALU operation select and
// conditional-branch FUNCT3 values.
package exec_unit_pkg;

    // ALU_FUN operation codes; any value not listed yields a zero result.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_LUI  = 4'b1001
    } alu_fun_e;

    // Conditional-branch FUNCT3 encodings; 010 and 011 are never taken.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_funct3_e;

endpackage

// File: rtl/exec_unit_alu_core.sv
// alu_core: purely combinational integer ALU for the execute stage.
module alu_core
    import exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_fun,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;

    // Only the low five bits of SRC_B select the shift distance.
    assign shamt = src_b[4:0];

    // Operation select; unlisted codes fall through to zero.
    always_comb begin
        // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
        result = '0;
        case (alu_fun_e'(alu_fun))
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_SLL:  result = src_a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SRL:  result = src_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
            ALU_OR:   result = src_a | src_b;
            ALU_AND:  result = src_a & src_b;
            ALU_LUI:  result = src_a;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage - ALU, branch compare, jump/branch target
// generation and the registered result/branch-decision outputs.
// Build option: define EXEC_UNIT_BRANCH_RESOLVE_EN to resolve conditional
// branches into TAKEN_Q; otherwise TAKEN_Q is tied to 0.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic [3:0]      ALU_FUN,
    input  logic [XLEN-1:0] SRC_A,
    input  logic [XLEN-1:0] SRC_B,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] I_IMM,
    input  logic [XLEN-1:0] B_IMM,
    input  logic [XLEN-1:0] J_IMM,
    input  logic [2:0]      FUNCT3,
    input  logic            BRANCH_OP,
    output logic [XLEN-1:0] RESULT,
    output logic            BR_EQ,
    output logic            BR_LT,
    output logic            BR_LTU,
    output logic [XLEN-1:0] JAL,
    output logic [XLEN-1:0] JALR,
    output logic [XLEN-1:0] BRANCH,
    output logic [XLEN-1:0] RESULT_Q,
    output logic            TAKEN_Q
);

    logic taken;

    alu_core #(.XLEN(XLEN)) u_alu (
        .alu_fun (ALU_FUN),
        .src_a   (SRC_A),
        .src_b   (SRC_B),
        .result  (RESULT)
    );

    // Register-operand compare flags feeding the branch decision.
    assign BR_EQ  = (RS1 == RS2);
    assign BR_LT  = ($signed(RS1) < $signed(RS2));
    assign BR_LTU = (RS1 < RS2);

    // Jump and branch targets; JALR clears bit 0 of the computed address.
    assign JAL    = PC + J_IMM;
    assign BRANCH = PC + B_IMM;
    assign JALR   = (RS1 + I_IMM) & {{(XLEN-1){1'b1}}, 1'b0};

`ifdef EXEC_UNIT_BRANCH_RESOLVE_EN
    // Branch decision from FUNCT3 and the compare flags, gated by BRANCH_OP.
    always_comb begin
        taken = 1'b0;
        if (BRANCH_OP) begin
            case (br_funct3_e'(FUNCT3))
                BR_BEQ:  taken = BR_EQ;
                BR_BNE:  taken = !BR_EQ;
                BR_BLT:  taken = BR_LT;
                BR_BGE:  taken = !BR_LT;
                BR_BLTU: taken = BR_LTU;
                BR_BGEU: taken = !BR_LTU;
                default: taken = 1'b0;
            endcase
        end
    end
`else
    logic unused_branch_inputs;

    // Branch resolution is not built: decision is constant and inputs are sunk.
    assign taken                = 1'b0;
    assign unused_branch_inputs = ^{FUNCT3, BRANCH_OP};
`endif

    // Stage registers: asynchronous clear, capture only when EN is high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RESULT_Q <= '0;
            TAKEN_Q  <= 1'b0;
        end else if (EN) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            RESULT_Q <= RESULT;
            TAKEN_Q  <= taken;
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed self-checking bench for exec_unit. Registered
// outputs are checked through a scoreboard filled when stimulus is applied
// with EN high and drained after each rising edge.
module tb_exec_unit;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0] result;
        logic        taken;
    } exp_t;

    logic            CLK;
    logic            RST;
    logic            EN;
    logic [3:0]      ALU_FUN;
    logic [XLEN-1:0] SRC_A, SRC_B, RS1, RS2, PC, I_IMM, B_IMM, J_IMM;
    logic [2:0]      FUNCT3;
    logic            BRANCH_OP;
    logic [XLEN-1:0] RESULT, JAL, JALR, BRANCH, RESULT_Q;
    logic            BR_EQ, BR_LT, BR_LTU, TAKEN_Q;

    exp_t        exp_q[$];
    logic [31:0] mdl_result;
    logic        mdl_taken;
    int          total;
    int          bad;

    exec_unit #(.XLEN(XLEN)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .ALU_FUN   (ALU_FUN),
        .SRC_A     (SRC_A),
        .SRC_B     (SRC_B),
        .RS1       (RS1),
        .RS2       (RS2),
        .PC        (PC),
        .I_IMM     (I_IMM),
        .B_IMM     (B_IMM),
        .J_IMM     (J_IMM),
        .FUNCT3    (FUNCT3),
        .BRANCH_OP (BRANCH_OP),
        .RESULT    (RESULT),
        .BR_EQ     (BR_EQ),
        .BR_LT     (BR_LT),
        .BR_LTU    (BR_LTU),
        .JAL       (JAL),
        .JALR      (JALR),
        .BRANCH    (BRANCH),
        .RESULT_Q  (RESULT_Q),
        .TAKEN_Q   (TAKEN_Q)
    );

    // 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within the time limit");
        $fatal(1, "timeout");
    end

    // Reference ALU written from the operation table.
    function automatic logic [31:0] alu_model(input logic [3:0] fun, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh = int'(b[4:0]);
        case (fun)
            4'b0000: return a + b;
            4'b1000: return a + ~b + 32'd1;
            4'b0001: return a << sh;
            4'b0010: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
            4'b0011: return {31'd0, (a < b)};
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1001: return a;
            default: return 32'd0;
        endcase
    endfunction

    // Reference branch decision; constant 0 when resolution is not built.
    function automatic logic taken_model(input logic bop, input logic [2:0] f3,
                                         input logic [31:0] r1, input logic [31:0] r2);
`ifdef EXEC_UNIT_BRANCH_RESOLVE_EN
        logic eq, lt, ltu;
        eq  = (r1 == r2);
        ltu = (r1 < r2);
        lt  = (r1[31] != r2[31]) ? r1[31] : ltu;
        if (!bop) return 1'b0;
        case (f3)
            3'b000: return eq;
            3'b001: return !eq;
            3'b100: return lt;
            3'b101: return !lt;
            3'b110: return ltu;
            3'b111: return !ltu;
            default: return 1'b0;
        endcase
`else
        return 1'b0 & bop & f3[0] & r1[0] & r2[0];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One rising edge: queue the expected capture if EN is high, then compare
    // the registered outputs just after the edge.
    task automatic tick(input string tag);
        exp_t e;
        if (EN) begin
            e.result = alu_model(ALU_FUN, SRC_A, SRC_B);
            e.taken  = taken_model(BRANCH_OP, FUNCT3, RS1, RS2);
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            e          = exp_q.pop_front();
            mdl_result = e.result;
            mdl_taken  = e.taken;
        end
        check({tag, "_result_q"}, RESULT_Q, mdl_result);
        check({tag, "_taken_q"}, {31'd0, TAKEN_Q}, {31'd0, mdl_taken});
    endtask

    task automatic set_alu(input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b);
        ALU_FUN = fun;
        SRC_A   = a;
        SRC_B   = b;
    endtask

    initial begin
        logic [3:0] fun;
        total      = 0;
        bad        = 0;
        mdl_result = '0;
        mdl_taken  = 1'b0;
        RST = 1'b0; EN = 1'b0; ALU_FUN = '0; SRC_A = '0; SRC_B = '0;
        RS1 = '0; RS2 = '0; PC = '0; I_IMM = '0; B_IMM = '0; J_IMM = '0;
        FUNCT3 = '0; BRANCH_OP = 1'b0;

        // Reset state, and no capture while reset is held even with EN high.
        #3;
        check("rst_result_q", RESULT_Q, 32'd0);
        check("rst_taken_q", {31'd0, TAKEN_Q}, 32'd0);
        EN = 1'b1;
        set_alu(4'b1000, 32'd5, 32'd7);
        @(posedge CLK);
        #1;
        check("rst_hold_result_q", RESULT_Q, 32'd0);
        check("rst_comb_result", RESULT, 32'hFFFF_FFFE);
        RST = 1'b1;

        // SUB 5-7 combinationally and one cycle later in RESULT_Q.
        #1;
        check("sub_comb", RESULT, 32'hFFFF_FFFE);
        tick("sub");
        check("sub_q_const", RESULT_Q, 32'hFFFF_FFFE);

        // Shift and compare boundaries.
        set_alu(4'b1101, 32'h8000_0000, 32'h0000_0024);
        #1 check("sra_comb", RESULT, 32'hF800_0000);
        tick("sra");
        set_alu(4'b0011, 32'd1, 32'hFFFF_FFFF);
        #1 check("sltu_comb", RESULT, 32'd1);
        tick("sltu");
        set_alu(4'b0010, 32'd1, 32'hFFFF_FFFF);
        #1 check("slt_comb", RESULT, 32'd0);
        tick("slt");
        set_alu(4'b0001, 32'h0000_0003, 32'hFFFF_FFFF);
        #1 check("sll31_comb", RESULT, 32'h8000_0000);
        tick("sll31");
        set_alu(4'b0000, 32'hFFFF_FFFF, 32'd2);
        #1 check("add_wrap_comb", RESULT, 32'd1);
        tick("add_wrap");

        // Every ALU_FUN code, including the unlisted ones, on two operand pairs.
        for (int i = 0; i < 16; i++) begin
            fun = 4'(i);
            set_alu(fun, 32'hA5A5_0F0F, 32'h0000_0107);
            #1 check($sformatf("alu%0d_p0", i), RESULT, alu_model(fun, SRC_A, SRC_B));
            tick($sformatf("alu%0d_p0", i));
            set_alu(fun, 32'h7F00_00C3, 32'h8000_0FF4);
            #1 check($sformatf("alu%0d_p1", i), RESULT, alu_model(fun, SRC_A, SRC_B));
            tick($sformatf("alu%0d_p1", i));
        end

        // Random operands through the scoreboard.
        for (int i = 0; i < 24; i++) begin
            set_alu(4'($urandom_range(0, 15)), $urandom, $urandom);
            RS1 = $urandom; RS2 = (i % 4 == 0) ? RS1 : $urandom;
            FUNCT3 = 3'($urandom_range(0, 7)); BRANCH_OP = 1'($urandom_range(0, 1));
            #1 check("rand_comb", RESULT, alu_model(ALU_FUN, SRC_A, SRC_B));
            tick("rand");
        end
        BRANCH_OP = 1'b0;

        // Compare flags.
        RS1 = 32'hFFFF_FFFF; RS2 = 32'd1;
        #1;
        check("cmp_eq", {31'd0, BR_EQ}, 32'd0);
        check("cmp_lt", {31'd0, BR_LT}, 32'd1);
        check("cmp_ltu", {31'd0, BR_LTU}, 32'd0);
        RS1 = 32'd3; RS2 = 32'd3;
        #1 check("cmp_eq_same", {31'd0, BR_EQ}, 32'd1);

        // Target addresses.
        PC = 32'h100; J_IMM = -32'sd8; B_IMM = 32'd16; RS1 = 32'h203; I_IMM = 32'd4;
        #1;
        check("jal", JAL, 32'h0000_00F8);
        check("branch", BRANCH, 32'h0000_0110);
        check("jalr", JALR, 32'h0000_0206);
        PC = 32'hFFFF_FFF0; J_IMM = 32'h20; I_IMM = 32'h0;
        #1;
        check("jal_wrap", JAL, 32'h0000_0010);

        // Branch decision on BGE/BLT with RS1=-1, RS2=0.
        BRANCH_OP = 1'b1; FUNCT3 = 3'b101; RS1 = 32'hFFFF_FFFF; RS2 = 32'd0;
        tick("bge");
        check("bge_taken", {31'd0, TAKEN_Q}, 32'd0);
        FUNCT3 = 3'b100;
        tick("blt");
`ifdef EXEC_UNIT_BRANCH_RESOLVE_EN
        check("blt_taken", {31'd0, TAKEN_Q}, 32'd1);
`else
        check("blt_taken", {31'd0, TAKEN_Q}, 32'd0);
`endif
        BRANCH_OP = 1'b0;

        // Stall: RESULT_Q = 9, then EN low for three edges with changing inputs.
        set_alu(4'b0000, 32'd4, 32'd5);
        tick("load9");
        check("load9_const", RESULT_Q, 32'd9);
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_alu(4'($urandom_range(0, 15)), $urandom, $urandom);
            tick("stall");
            check("stall_const", RESULT_Q, 32'd9);
        end

        // Reset pulse between edges clears immediately; comb path unaffected.
        set_alu(4'b0110, 32'hF0F0_0000, 32'h0000_0F0F);
        #1 RST = 1'b0;
        #1;
        check("rst_pulse_result_q", RESULT_Q, 32'd0);
        check("rst_pulse_taken_q", {31'd0, TAKEN_Q}, 32'd0);
        check("rst_pulse_comb", RESULT, 32'hF0F0_0F0F);
        RST = 1'b1;
        exp_q.delete();
        mdl_result = '0;
        mdl_taken  = 1'b0;
        EN = 1'b1;
        tick("post_rst");
        check("post_rst_const", RESULT_Q, 32'hF0F0_0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
